first_nios2_system_sysid_arbiter: RTL and testbench

FIRST_NIOS2_SYSTEM_SYSID_ARBITER -- requirements
Module: first_nios2_system_sysid_arbiter

---
 rtl/first_nios2_system_sysid_arbiter.sv | 107 ++++++++++
 tb/tb_first_nios2_system_sysid_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/first_nios2_system_sysid_arbiter.sv
// Two-master read arbiter in front of a zero-wait-state, read-only system ID slave.
// Each transfer takes IDLE -> ISSUE -> RESP, so there is at most one read every three cycles.
// Define SYSID_ARB_ROUND_ROBIN_EN to get round-robin tie breaking.
// Without it, master 0 wins every tie.
module first_nios2_system_sysid_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m0_read,
  input  logic        m0_address,
  output logic        m0_waitrequest,
  output logic        m0_readdatavalid,
  output logic [31:0] m0_readdata,
  input  logic        m1_read,
  input  logic        m1_address,
  output logic        m1_waitrequest,
  output logic        m1_readdatavalid,
  output logic [31:0] m1_readdata,
  output logic        s_address,
  input  logic [31:0] s_readdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;  // 0 = master 0, 1 = master 1
  logic [31:0] data_q, data_d;
  logic        winner;
  logic        grant_read;

`ifdef SYSID_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // A tie goes to the master that was not served last.
  always_comb begin
    if (m0_read && m1_read) winner = ~last_grant_q;
    else                    winner = m1_read;
  end

  // Record the master served by each transfer that completes.
  // Reset to 1 so that the first tie goes to master 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else if (state_q == StResp) begin
      last_grant_q <= grant_q;
    end
  end
`else
  // Fixed priority: master 1 wins only when master 0 is not requesting.
  always_comb begin
    winner = ~m0_read;
  end
`endif

  // State, grant and captured data registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, capture in ISSUE, return in RESP.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    data_d     = data_q;
    grant_read = grant_q ? m1_read : m0_read;
    unique case (state_q)
      StIdle: begin
        if (m0_read || m1_read) begin
          grant_d = winner;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // If the granted master dropped read, abandon the transfer and keep the data.
        if (grant_read) begin
          data_d  = s_readdata;
          state_d = StResp;
        end else begin
          state_d = StIdle;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: only the granted master sees waitrequest drop, and only during ISSUE.
  always_comb begin
    m0_waitrequest   = !((state_q == StIssue) && !grant_q);
    m1_waitrequest   = !((state_q == StIssue) && grant_q);
    m0_readdatavalid = (state_q == StResp) && !grant_q;
    m1_readdatavalid = (state_q == StResp) && grant_q;
    m0_readdata      = data_q;
    m1_readdata      = data_q;
    s_address        = 1'b0;
    if (state_q == StIssue) s_address = grant_q ? m1_address : m0_address;
  end

endmodule

// File: tb/tb_first_nios2_system_sysid_arbiter.sv
// Directed self-checking bench for first_nios2_system_sysid_arbiter.
// Honours SYSID_ARB_ROUND_ROBIN_EN when the macro is defined at build time.
module tb_first_nios2_system_sysid_arbiter;

  localparam logic [31:0] IdWord = 32'h56A64376;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        m0_read, m0_address, m1_read, m1_address;
  logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic        s_address;
  logic [31:0] s_readdata;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Slave model: the ID word at address 1, zero at address 0.
  assign s_readdata = s_address ? IdWord : 32'h0;

  always #5 clock = ~clock;

  first_nios2_system_sysid_arbiter dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .m0_read          (m0_read),
    .m0_address       (m0_address),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdatavalid (m0_readdatavalid),
    .m0_readdata      (m0_readdata),
    .m1_read          (m1_read),
    .m1_address       (m1_address),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_readdata      (m1_readdata),
    .s_address        (s_address),
    .s_readdata       (s_readdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    m0_read = 1'b0; m0_address = 1'b1;
    m1_read = 1'b0; m1_address = 1'b0;
    #12;
    check("rst_wr0", 32'(m0_waitrequest), 32'd1);
    check("rst_wr1", 32'(m1_waitrequest), 32'd1);
    check("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
    check("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
    check("rst_saddr", 32'(s_address), 32'd0);
    check("rst_rd0", m0_readdata, 32'h0);
    check("rst_rd1", m1_readdata, 32'h0);
    step();
    reset_n = 1'b1;
    step();

    // Single m0 read of address 1.
    m0_read = 1'b1; m0_address = 1'b1;
    check("t1_idle_wr0", 32'(m0_waitrequest), 32'd1);
    check("t1_idle_saddr", 32'(s_address), 32'd0);
    step();  // ISSUE
    check("t1_iss_wr0", 32'(m0_waitrequest), 32'd0);
    check("t1_iss_wr1", 32'(m1_waitrequest), 32'd1);
    check("t1_iss_saddr", 32'(s_address), 32'd1);
    check("t1_iss_rdv0", 32'(m0_readdatavalid), 32'd0);
    step();  // RESP
    m0_read = 1'b0;
    check("t1_resp_rdv0", 32'(m0_readdatavalid), 32'd1);
    check("t1_resp_rd0", m0_readdata, IdWord);
    check("t1_resp_rdv1", 32'(m1_readdatavalid), 32'd0);
    check("t1_resp_wr0", 32'(m0_waitrequest), 32'd1);
    step();  // IDLE
    check("t1_idle2_rdv0", 32'(m0_readdatavalid), 32'd0);
    check("t1_idle2_rd0", m0_readdata, IdWord);

    // m0 drops read in ISSUE: abort, data stays.
    m0_read = 1'b1; m0_address = 1'b0;
    step();  // ISSUE
    m0_read = 1'b0;
    check("t2_iss_wr0", 32'(m0_waitrequest), 32'd0);
    step();  // back to IDLE
    check("t2_rdv0", 32'(m0_readdatavalid), 32'd0);
    check("t2_rd0", m0_readdata, IdWord);
    check("t2_wr0", 32'(m0_waitrequest), 32'd1);
    step();
    check("t2_rdv0_later", 32'(m0_readdatavalid), 32'd0);

    // m1 arrives while m0 is in ISSUE and is served right after.
    m0_read = 1'b1; m0_address = 1'b1;
    step();  // m0 ISSUE
    m1_read = 1'b1; m1_address = 1'b0;
    check("t3_iss_wr1", 32'(m1_waitrequest), 32'd1);
    step();  // m0 RESP
    m0_read = 1'b0;
    check("t3_rdv0", 32'(m0_readdatavalid), 32'd1);
    check("t3_resp_wr1", 32'(m1_waitrequest), 32'd1);
    step();  // IDLE
    check("t3_idle_rdv1", 32'(m1_readdatavalid), 32'd0);
    step();  // m1 ISSUE
    check("t3_iss1_wr1", 32'(m1_waitrequest), 32'd0);
    check("t3_iss1_wr0", 32'(m0_waitrequest), 32'd1);
    step();  // m1 RESP, 3 cycles after m0's pulse
    m1_read = 1'b0;
    check("t3_rdv1", 32'(m1_readdatavalid), 32'd1);
    check("t3_rd1", m1_readdata, 32'h0);
    check("t3_rd0_shared", m0_readdata, 32'h0);
    step();  // IDLE

    // Both masters hold read continuously.
    m0_read = 1'b1; m0_address = 1'b1;
    m1_read = 1'b1; m1_address = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic exp_g;
`ifdef SYSID_ARB_ROUND_ROBIN_EN
      exp_g = k[0];
`else
      exp_g = 1'b0;
`endif
      step();  // ISSUE
      check($sformatf("t4_wr0_%0d", k), 32'(m0_waitrequest), 32'(exp_g));
      check($sformatf("t4_wr1_%0d", k), 32'(m1_waitrequest), 32'(!exp_g));
      step();  // RESP
      check($sformatf("t4_rdv0_%0d", k), 32'(m0_readdatavalid), 32'(!exp_g));
      check($sformatf("t4_rdv1_%0d", k), 32'(m1_readdatavalid), 32'(exp_g));
      check($sformatf("t4_rd_%0d", k), m0_readdata, exp_g ? 32'h0 : IdWord);
      step();  // IDLE
      check($sformatf("t4_idle_wr1_%0d", k), 32'(m1_waitrequest), 32'd1);
    end
    m0_read = 1'b0; m1_read = 1'b0;
    step();

    // Reset during RESP aborts the pulse, clears the data and resets the tie winner.
    m0_read = 1'b1; m0_address = 1'b1;
    step();  // ISSUE
    step();  // RESP
    m0_read = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t5_rst_rdv0", 32'(m0_readdatavalid), 32'd0);
    check("t5_rst_rd0", m0_readdata, 32'h0);
    check("t5_rst_wr0", 32'(m0_waitrequest), 32'd1);
    check("t5_rst_wr1", 32'(m1_waitrequest), 32'd1);
    check("t5_rst_saddr", 32'(s_address), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("t5_post_rdv0", 32'(m0_readdatavalid), 32'd0);
    check("t5_post_rd0", m0_readdata, 32'h0);
    m0_read = 1'b1; m1_read = 1'b1;
    step();  // ISSUE, m0 wins the tie
    check("t5_tie_wr0", 32'(m0_waitrequest), 32'd0);
    check("t5_tie_wr1", 32'(m1_waitrequest), 32'd1);
    step();  // RESP
    m0_read = 1'b0; m1_read = 1'b0;
    check("t5_tie_rdv0", 32'(m0_readdatavalid), 32'd1);
    check("t5_tie_rd0", m0_readdata, IdWord);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
